// File: rtl/soc_gpio_arbiter.sv
// Two-master round-robin sequencer for the GPIO register port.
// Grants one access at a time and drives a single-cycle GPIO command.
// It then waits for gpio_ready and answers the granted master with ack or timeout error.
module soc_gpio_arbiter #(
  parameter int unsigned IO_MAP_WIDTH   = 32,
  parameter int unsigned TIMEOUT_CYCLES = 8,
  parameter logic [3:0]  IDLE_ADDR      = 4'hF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_req,
  input  logic                    m0_we,
  input  logic [3:0]              m0_addr,
  input  logic [IO_MAP_WIDTH-1:0] m0_wdata,
  output logic                    m0_ack,
  output logic                    m0_err,
  output logic [IO_MAP_WIDTH-1:0] m0_rdata,
  input  logic                    m1_req,
  input  logic                    m1_we,
  input  logic [3:0]              m1_addr,
  input  logic [IO_MAP_WIDTH-1:0] m1_wdata,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic [IO_MAP_WIDTH-1:0] m1_rdata,
  output logic                    gpio_we,
  output logic [3:0]              gpio_addr,
  output logic [IO_MAP_WIDTH-1:0] gpio_wdata,
  input  logic [IO_MAP_WIDTH-1:0] gpio_rdata,
  input  logic                    gpio_ready,
  output logic                    busy,
  output logic                    grant
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic                    r_we, w_we_nxt;
  logic                    r_grant, w_grant_nxt;
  logic                    r_last_grant, w_last_grant_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_gpio_we, w_gpio_we_nxt;
  logic [3:0]              r_gpio_addr, w_gpio_addr_nxt;
  logic [IO_MAP_WIDTH-1:0] r_gpio_wdata, w_gpio_wdata_nxt;
  logic                    r_m0_ack, w_m0_ack_nxt;
  logic                    r_m0_err, w_m0_err_nxt;
  logic [IO_MAP_WIDTH-1:0] r_m0_rdata, w_m0_rdata_nxt;
  logic                    r_m1_ack, w_m1_ack_nxt;
  logic                    r_m1_err, w_m1_err_nxt;
  logic [IO_MAP_WIDTH-1:0] r_m1_rdata, w_m1_rdata_nxt;

  logic                    w_winner;
  logic                    w_sel_we;
  logic [3:0]              w_sel_addr;
  logic [IO_MAP_WIDTH-1:0] w_sel_wdata;
  logic [IO_MAP_WIDTH-1:0] w_resp_rdata;

  // Next-state and next-output decode; every output is registered from these values
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_we_nxt         = r_we;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_gpio_we_nxt    = 1'b0;
    w_gpio_addr_nxt  = IDLE_ADDR;
    w_gpio_wdata_nxt = r_gpio_wdata;
    w_m0_ack_nxt     = 1'b0;
    w_m0_err_nxt     = 1'b0;
    w_m0_rdata_nxt   = '0;
    w_m1_ack_nxt     = 1'b0;
    w_m1_err_nxt     = 1'b0;
    w_m1_rdata_nxt   = '0;
    // On a tie the master that did not own the previous access wins
    w_winner         = m1_req & (~m0_req | ~r_last_grant);
    w_sel_we         = w_winner ? m1_we    : m0_we;
    w_sel_addr       = w_winner ? m1_addr  : m0_addr;
    w_sel_wdata      = w_winner ? m1_wdata : m0_wdata;
    w_resp_rdata     = r_we ? '0 : gpio_rdata;

    unique case (r_state)
      S_IDLE: begin
        if (m0_req | m1_req) begin
          w_state_nxt      = S_ISSUE;
          w_we_nxt         = w_sel_we;
          w_grant_nxt      = w_winner;
          w_gpio_we_nxt    = w_sel_we;
          w_gpio_addr_nxt  = w_sel_addr;
          w_gpio_wdata_nxt = w_sel_wdata;
        end
      end
      S_ISSUE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A ready arriving in the final wait cycle still completes normally
        if (gpio_ready) begin
          w_state_nxt = S_RESP;
          if (r_grant) begin
            w_m1_ack_nxt   = 1'b1;
            w_m1_rdata_nxt = w_resp_rdata;
          end else begin
            w_m0_ack_nxt   = 1'b1;
            w_m0_rdata_nxt = w_resp_rdata;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt  = S_RESP;
          w_m0_err_nxt = ~r_grant;
          w_m1_err_nxt = r_grant;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RESP: begin
        w_last_grant_nxt = r_grant;
        w_state_nxt      = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers; reset drops any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_busy       <= 1'b0;
      r_gpio_we    <= 1'b0;
      r_gpio_addr  <= IDLE_ADDR;
      r_gpio_wdata <= '0;
      r_m0_ack     <= 1'b0;
      r_m0_err     <= 1'b0;
      r_m0_rdata   <= '0;
      r_m1_ack     <= 1'b0;
      r_m1_err     <= 1'b0;
      r_m1_rdata   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_we         <= w_we_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_busy       <= w_busy_nxt;
      r_gpio_we    <= w_gpio_we_nxt;
      r_gpio_addr  <= w_gpio_addr_nxt;
      r_gpio_wdata <= w_gpio_wdata_nxt;
      r_m0_ack     <= w_m0_ack_nxt;
      r_m0_err     <= w_m0_err_nxt;
      r_m0_rdata   <= w_m0_rdata_nxt;
      r_m1_ack     <= w_m1_ack_nxt;
      r_m1_err     <= w_m1_err_nxt;
      r_m1_rdata   <= w_m1_rdata_nxt;
    end
  end

  assign m0_ack     = r_m0_ack;
  assign m0_err     = r_m0_err;
  assign m0_rdata   = r_m0_rdata;
  assign m1_ack     = r_m1_ack;
  assign m1_err     = r_m1_err;
  assign m1_rdata   = r_m1_rdata;
  assign gpio_we    = r_gpio_we;
  assign gpio_addr  = r_gpio_addr;
  assign gpio_wdata = r_gpio_wdata;
  assign busy       = r_busy;
  assign grant      = r_grant;

endmodule

// File: tb/tb_soc_gpio_arbiter.sv
// Bench for soc_gpio_arbiter: queued master stimulus, a behavioural GPIO responder,
// and a scoreboard of expected responses and GPIO commands compared at each negedge.
module tb_soc_gpio_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        gpio_we;
  logic [3:0]  gpio_addr;
  logic [31:0] gpio_wdata, gpio_rdata;
  logic        gpio_ready;
  logic        busy, grant;

  soc_gpio_arbiter #(
    .IO_MAP_WIDTH(32), .TIMEOUT_CYCLES(8), .IDLE_ADDR(4'hF)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .gpio_we(gpio_we), .gpio_addr(gpio_addr), .gpio_wdata(gpio_wdata),
    .gpio_rdata(gpio_rdata), .gpio_ready(gpio_ready),
    .busy(busy), .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    logic        master;
    logic        is_err;
    logic        dropped;
    logic [31:0] rdata;
    int          lat;
    logic        g_we;
    logic [3:0]  g_addr;
    logic [31:0] g_wdata;
  } exp_t;

  acc_t q0[$];
  acc_t q1[$];
  exp_t sb[$];

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   issue_cyc = 0;
  logic prev_issue = 1'b0;
  logic pend = 1'b0;
  logic kick = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Queue one access for a master together with its expected GPIO command and response
  task automatic access(input logic m, input logic we, input logic [3:0] addr,
                        input logic [31:0] wdata, input logic is_err,
                        input logic [31:0] rdata, input int lat, input logic dropped);
    acc_t a;
    exp_t e;
    a.we = we; a.addr = addr; a.wdata = wdata;
    if (m) q1.push_back(a); else q0.push_back(a);
    e.master = m; e.is_err = is_err; e.dropped = dropped; e.rdata = rdata; e.lat = lat;
    e.g_we = we; e.g_addr = addr; e.g_wdata = wdata;
    sb.push_back(e);
  endtask

  // One clock: monitor outputs, model the GPIO, then drive the masters
  task automatic step();
    logic r0, r1;
    exp_t e;
    @(negedge clk);
    cyc++;
    r0 = m0_ack | m0_err;
    r1 = m1_ack | m1_err;
    if (rst) begin
      if (sb.size() > 0 && sb[0].dropped) void'(sb.pop_front());
      q0.delete();
      q1.delete();
      pend = 1'b0;
      prev_issue = 1'b0;
      gpio_ready = 1'b0;
    end else begin
      if (prev_issue) begin
        chk("post_issue_we", 32'(gpio_we), 32'd0);
        chk("post_issue_addr", 32'(gpio_addr), 32'hF);
      end
      prev_issue = 1'b0;
      gpio_ready = kick;
      kick = 1'b0;
      if (pend) begin
        gpio_ready = 1'b1;
        pend = 1'b0;
      end
      if (gpio_addr != 4'hF) begin
        if (sb.size() == 0) begin
          chk("issue_unexpected", 32'(gpio_addr), 32'hF);
        end else begin
          chk("issue_we", 32'(gpio_we), 32'(sb[0].g_we));
          chk("issue_addr", 32'(gpio_addr), 32'(sb[0].g_addr));
          chk("issue_wdata", gpio_wdata, sb[0].g_wdata);
        end
        issue_cyc = cyc;
        prev_issue = 1'b1;
        pend = gpio_we ? (gpio_addr == 4'h0 || gpio_addr == 4'h4) : (gpio_addr == 4'h8);
      end
      if (!m0_ack) chk("m0_rdata_idle", m0_rdata, 32'd0);
      if (!m1_ack) chk("m1_rdata_idle", m1_rdata, 32'd0);
      if (r0 | r1) begin
        chk("dual_resp", 32'(r0 & r1), 32'd0);
        if (sb.size() == 0 || sb[0].dropped) begin
          chk("unexpected_resp", 32'({r0, r1}), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("resp_master", 32'(r1), 32'(e.master));
          chk("resp_grant", 32'(grant), 32'(e.master));
          chk("resp_err", 32'(r1 ? m1_err : m0_err), 32'(e.is_err));
          chk("resp_ack", 32'(r1 ? m1_ack : m0_ack), 32'(!e.is_err));
          chk("resp_rdata", r1 ? m1_rdata : m0_rdata, e.rdata);
          chk("resp_latency", 32'(cyc - issue_cyc), 32'(e.lat));
        end
      end
    end
    if ((m0_ack | m0_err) && q0.size() > 0) void'(q0.pop_front());
    if ((m1_ack | m1_err) && q1.size() > 0) void'(q1.pop_front());
    m0_req = 1'b0;
    m1_req = 1'b0;
    if (!rst && q0.size() > 0) begin
      m0_req = 1'b1; m0_we = q0[0].we; m0_addr = q0[0].addr; m0_wdata = q0[0].wdata;
    end
    if (!rst && q1.size() > 0) begin
      m1_req = 1'b1; m1_we = q1[0].we; m1_addr = q1[0].addr; m1_wdata = q1[0].wdata;
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(sb.size() == 0 && q0.size() == 0 && q1.size() == 0 && busy == 1'b0) && n < budget);
    chk("drain_pending", 32'(sb.size()), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 4'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 4'h0; m1_wdata = 32'h0;
    gpio_rdata = 32'h0; gpio_ready = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_gpio_we", 32'(gpio_we), 32'd0);
    chk("rst_gpio_addr", 32'(gpio_addr), 32'hF);
    chk("rst_gpio_wdata", gpio_wdata, 32'd0);
    chk("rst_acks", 32'({m0_ack, m0_err, m1_ack, m1_err}), 32'd0);
    rst = 1'b0;
    step();

    // m0 write 0xFF to out register
    gpio_rdata = 32'h1357_9BDF;
    access(1'b0, 1'b1, 4'h4, 32'h0000_00FF, 1'b0, 32'h0, 2, 1'b0);
    wait_done(40);

    // m1 read of the input register
    gpio_rdata = 32'hA5A5_5A5A;
    access(1'b1, 1'b0, 4'h8, 32'h0000_1111, 1'b0, 32'hA5A5_5A5A, 2, 1'b0);
    wait_done(40);

    // Both masters from reset, four accesses each: strict alternation starting with m0
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    gpio_rdata = 32'h0BAD_F00D;
    for (int i = 0; i < 4; i++) begin
      access(1'b0, 1'b1, (i % 2 == 0) ? 4'h4 : 4'h0, 32'(i + 16), 1'b0, 32'h0, 2, 1'b0);
      access(1'b1, 1'b0, 4'h8, 32'(i), 1'b0, 32'h0BAD_F00D, 2, 1'b0);
    end
    wait_done(100);

    // Unanswered read of the mode register times out
    access(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0, 9, 1'b0);
    wait_done(60);

    // Reset while waiting on an unanswered read drops the access silently
    access(1'b1, 1'b0, 4'h4, 32'h0, 1'b0, 32'h0, 0, 1'b1);
    repeat (4) step();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_gpio_we", 32'(gpio_we), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("post_rst_pending", 32'(sb.size()), 32'd0);
    gpio_rdata = 32'h2468_ACE0;
    access(1'b1, 1'b0, 4'h8, 32'h0, 1'b0, 32'h2468_ACE0, 2, 1'b0);
    wait_done(40);

    // Stray ready while idle is ignored
    kick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stray_ready_busy", 32'(busy), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
